// File: rtl/kiwi_ksubs_pkg.sv
// kiwi_ksubs_pkg: shared run states, exit syndromes and LED layout for the KiwiC run-control block
package kiwi_ksubs_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, ST_ABEND = 2'd3} state_e;
   localparam logic [7:0] SYN_NONE    = 8'h00;
   localparam logic [7:0] SYN_OK      = 8'h80;
   localparam logic [7:0] SYN_TIMEOUT = 8'hFE;
   localparam int LED_TERM  = 7;
   localparam int LED_ABEND = 6;
   localparam int LED_RUN   = 5;
   function automatic logic [3:0] fin_count(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return (n > 5'd15) ? 4'hF : n[3:0];
   endfunction
endpackage

// File: rtl/kiwi_prio_pick.sv
// kiwi_prio_pick: lowest-index priority encoder over a request vector
module kiwi_prio_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0] req_i,
   output logic [3:0]   idx_o,
   output logic         any_o
);
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = 4'(i);
   end
   assign any_o = |req_i;
endmodule

// File: rtl/kiwi_ksubs_director.sv
// kiwi_ksubs_director: multi-thread run control, exit syndrome, waypoint and status LED capture
module kiwi_ksubs_director
   import kiwi_ksubs_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int PC_W     = 2,
   parameter int CNT_W    = 32,
   parameter int TIMEOUT  = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     clear,
   input  logic [CHANNELS-1:0]      fin,
   input  logic [8*CHANNELS-1:0]    abend_code,
   input  logic [CHANNELS-1:0]      wp_valid,
   input  logic [8*CHANNELS-1:0]    wp_code,
   input  logic [PC_W*CHANNELS-1:0] pc,
   output logic                     run,
   output logic [1:0]               state,
   output logic [7:0]               ksubsAbendSyndrome,
   output logic [7:0]               ksubsGpioLeds,
   output logic [7:0]               ksubsManualWaypoint,
   output logic [3:0]               wp_chan,
   output logic [CNT_W-1:0]         cycles,
   output logic [PC_W*CHANNELS-1:0] pc_export
);
   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cycles_q, cycles_d;
   logic [7:0]                syn_q, syn_d, wp_q, wp_d, leds_q, leds_d, a_code;
   logic [3:0]                wch_q, wch_d, a_idx, w_idx;
   logic [CHANNELS-1:0]       a_req;
   logic                      a_any, w_any, tmo, enter, in_run, term;
   logic [PC_W*CHANNELS-1:0]  pc_q;
   always_comb begin
      a_req = '0;
      for (int i = 0; i < CHANNELS; i++) a_req[i] = |abend_code[8*i +: 8];
   end
   kiwi_prio_pick #(.N(CHANNELS)) u_abend_pick (.req_i(a_req), .idx_o(a_idx), .any_o(a_any));
   kiwi_prio_pick #(.N(CHANNELS)) u_wp_pick (.req_i(wp_valid), .idx_o(w_idx), .any_o(w_any));
   assign a_code = abend_code[8*a_idx +: 8];
   assign tmo    = (TIMEOUT != 0) && (cycles_q == CNT_W'(TIMEOUT - 1));
   assign in_run = state_q == ST_RUN;
   assign enter  = (state_q == ST_IDLE) && start;
   assign term   = in_run && (a_any || tmo || &fin);
   always_ff @(posedge clk) state_q <= reset ? ST_IDLE : state_d;
   always_comb begin
      state_d = state_q;
      if (enter) state_d = ST_RUN;
      else if (term) state_d = (a_any || tmo) ? ST_ABEND : ST_DONE;
      else if ((state_q == ST_DONE || state_q == ST_ABEND) && clear) state_d = ST_IDLE;
   end
   // LEDs are registered from the next state so they move together with state
   always_comb begin
      leds_d            = '0;
      leds_d[LED_TERM]  = (state_d == ST_DONE) || (state_d == ST_ABEND);
      leds_d[LED_ABEND] = state_d == ST_ABEND;
      leds_d[LED_RUN]   = state_d == ST_RUN;
      leds_d[3:0]       = fin_count(16'(fin));
      cycles_d = enter ? '0 : (in_run && !term && !(&cycles_q)) ? cycles_q + CNT_W'(1) : cycles_q;
      syn_d    = enter ? SYN_NONE : term ? (a_any ? a_code : tmo ? SYN_TIMEOUT : SYN_OK) : syn_q;
      wp_d     = enter ? 8'h00 : (in_run && w_any) ? wp_code[8*w_idx +: 8] : wp_q;
      wch_d    = enter ? 4'h0 : (in_run && w_any) ? w_idx : wch_q;
   end
   always_ff @(posedge clk) begin
      cycles_q <= reset ? '0 : cycles_d;
      syn_q    <= reset ? '0 : syn_d;
      wp_q     <= reset ? '0 : wp_d;
      wch_q    <= reset ? '0 : wch_d;
      leds_q   <= reset ? '0 : leds_d;
      pc_q     <= reset ? '0 : pc;
   end
   assign run                 = in_run;
   assign state               = state_q;
   assign ksubsAbendSyndrome  = syn_q;
   assign ksubsGpioLeds       = leds_q;
   assign ksubsManualWaypoint = wp_q;
   assign wp_chan             = wch_q;
   assign cycles              = cycles_q;
   assign pc_export           = pc_q;
endmodule

// File: doc/kiwi_ksubs_director.md
# kiwi_ksubs_director

Parametrised run-control and status block for KiwiC-generated designs with several hardware threads. It starts the threads and collects each thread's finish, abend and waypoint reports. It produces the substrate status outputs: abend syndrome, GPIO LEDs, manual waypoint, a run-cycle count and registered per-thread PC exports. It sits between the host/bench and the generated DUT and replaces the single-thread, finish-immediately status logic of earlier builds.

## Interface
- CHANNELS, 2: number of hardware threads monitored (1..16).
- PC_W, 2: width of each thread's PC export.
- CNT_W, 32: width of the run-cycle counter.
- TIMEOUT, 0: watchdog limit in RUN cycles; 0 disables the watchdog.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a run.
- clear  in  1  single-cycle request to return to IDLE from DONE/ABEND.
- fin  in  CHANNELS  per-thread finished level, held once asserted.
- abend_code  in  8*CHANNELS  per-thread abend code; 0 means no abend.
- wp_valid  in  CHANNELS  per-thread waypoint strobe.
- wp_code  in  8*CHANNELS  per-thread waypoint value.
- pc  in  PC_W*CHANNELS  per-thread PC.
- run  out  1  thread enable, high only in RUN.
- state  out  2  IDLE=0, RUN=1, DONE=2, ABEND=3.
- ksubsAbendSyndrome  out  8  exit syndrome.
- ksubsGpioLeds  out  8  status LEDs.
- ksubsManualWaypoint  out  8  last waypoint value.
- wp_chan  out  4  channel that produced the last waypoint.
- cycles  out  CNT_W  RUN-cycle count.
- pc_export  out  PC_W*CHANNELS  pc delayed by one cycle.

## Operation
- Reset value of every output is 0, so state=IDLE and run=0.
- IDLE:
  - start=1 -> RUN next cycle.
  - Entering RUN clears cycles, ksubsAbendSyndrome, ksubsManualWaypoint and wp_chan.
- RUN: cycles increments each cycle, saturating at all-ones. Evaluated in priority order:
  1. Any abend_code≠0 -> ABEND. Syndrome is the code of the lowest-index abending channel.
  2. Otherwise, TIMEOUT≠0 and cycles==TIMEOUT-1 -> ABEND with syndrome 0xFE.
  3. Otherwise, all fin bits high -> DONE with syndrome 0x80 (normal exit).
- DONE/ABEND:
  - clear=1 -> IDLE. Syndrome, cycles and waypoint are held until the next start.
  - start is ignored in DONE/ABEND. clear is ignored in IDLE and RUN.
- Waypoints are accepted in RUN only. The lowest-index channel with wp_valid set wins; its wp_code and index are registered. Strobes on other channels in the same cycle are dropped.
- ksubsGpioLeds:
  - bit7 = DONE or ABEND.
  - bit6 = ABEND.
  - bit5 = run.
  - bits3:0 = count of fin bits set, saturating at 15.
- pc_export is a one-cycle register of pc in every state.

## Timing
- start at cycle t gives run=1 and state=RUN at t+1. The first counted cycle has cycles=1 at t+2.
- A terminating condition sampled at t gives state, run=0 and syndrome at t+1, all updated together. cycles holds the value it had at t.
- When abend and all-fin occur in the same cycle, abend wins. When abend and timeout coincide, the code from abend_code wins.
- fin already all-high on the cycle RUN is entered -> DONE one cycle later (minimum run of 1 cycle).
- reset asserted mid-RUN forces all outputs to 0 on the next edge. No run state is kept.
- Waypoint latency is 1 cycle. A waypoint strobe on the same cycle as a terminating condition is still captured.

## Structure
- Shared package `kiwi_ksubs_pkg` holds:
  - the state enum (IDLE/RUN/DONE/ABEND);
  - syndrome constants: SYN_NONE=0x00, SYN_OK=0x80, SYN_TIMEOUT=0xFE;
  - LED bit positions.
- One sub-module, `kiwi_prio_pick`: a parametrised lowest-index priority encoder (valid vector -> index + any). It is instantiated twice, for abend selection and for waypoint selection.

## Test plan
- CHANNELS=2, start, fin=2'b01 at +3, fin=2'b11 at +6 -> DONE, syndrome 0x80, LEDs 0x82, cycles=6, run=0.
- In RUN, abend_code[1]=0x21 and abend_code[0]=0x13 asserted together with fin=11 -> ABEND, syndrome 0x13, LEDs bit6=1.
- TIMEOUT=10, fin never set -> ABEND after cycles=9 reaches limit, syndrome 0xFE. clear -> IDLE with syndrome still 0xFE. Next start -> syndrome 0x00.
- wp_valid=2'b11 with wp_code 0x05/0x07 in RUN -> waypoint 0x05, wp_chan=0. Strobe in IDLE -> ignored.
- reset pulse mid-RUN with cycles=4 -> all outputs 0 next cycle. start is ignored while in DONE.
- pc ramp 0,1,2,3 -> pc_export shows the same sequence delayed exactly 1 cycle, in every state.
